// File: rtl/voice_allocator.sv
// voice_allocator: note-on/note-off scheduler for the synth voice pool.
// A linear scan over all voices picks the serving voice for each request.
// On a note-on the order of preference is: retrigger the voice already
// holding the key, then a free voice, then a released voice, then steal.
// Build option: define VOICE_STEAL_EN to enable voice stealing through a
// round-robin pointer. When it is undefined, a note-on with no usable voice
// is dropped and alloc_fail pulses.
module voice_allocator #(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = $clog2(VOICES)
) (
  input  logic               reg_clk,
  input  logic               reset_reg_N,
  input  logic               req_valid,
  input  logic               req_on,
  input  logic [7:0]         req_key,
  input  logic [7:0]         req_vel,
  input  logic [VOICES-1:0]  voice_free,
  output logic               req_ready,
  output logic               alloc_valid,
  output logic [V_WIDTH-1:0] alloc_adr,
  output logic [7:0]         alloc_key,
  output logic [7:0]         alloc_vel,
  output logic               alloc_on,
  output logic [VOICES-1:0]  keys_on,
  output logic [V_WIDTH:0]   active_keys,
  output logic               steal,
  output logic               off_note_error,
  output logic               alloc_fail
);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

  localparam logic [V_WIDTH-1:0] LAST = V_WIDTH'(VOICES - 1);

  state_t                   state_q, state_d;
  logic [V_WIDTH-1:0]       idx_q, idx_d;
  logic [7:0]               key_q, key_d, vel_q, vel_d;
  logic                     on_q, on_d;
  logic [VOICES-1:0]        free_snap_q, free_snap_d;
  logic                     m_hit_q, m_hit_d, f_hit_q, f_hit_d, r_hit_q, r_hit_d;
  logic [V_WIDTH-1:0]       m_idx_q, m_idx_d, f_idx_q, f_idx_d, r_idx_q, r_idx_d;
  logic [VOICES-1:0][7:0]   key_tab_q, key_tab_d;
  logic [VOICES-1:0]        keys_on_q, keys_on_d;
  logic [V_WIDTH:0]         active_q, active_d;
  logic                     req_ready_q, req_ready_d;
  logic                     alloc_valid_q, alloc_valid_d;
  logic [V_WIDTH-1:0]       alloc_adr_q, alloc_adr_d;
  logic [7:0]               alloc_key_q, alloc_key_d, alloc_vel_q, alloc_vel_d;
  logic                     alloc_on_q, alloc_on_d;
  logic                     off_err_q, off_err_d;
  logic                     fail_q, fail_d;
  logic                     cur_m, cur_f, cur_r, hit;
  logic [V_WIDTH-1:0]       sel;
`ifdef VOICE_STEAL_EN
  logic [V_WIDTH-1:0]       sp_q, sp_d;
  logic                     steal_q, steal_d;
`endif

  // Scan step, final voice selection and key-table update
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    key_d         = key_q;
    vel_d         = vel_q;
    on_d          = on_q;
    free_snap_d   = free_snap_q;
    m_hit_d       = m_hit_q;
    f_hit_d       = f_hit_q;
    r_hit_d       = r_hit_q;
    m_idx_d       = m_idx_q;
    f_idx_d       = f_idx_q;
    r_idx_d       = r_idx_q;
    key_tab_d     = key_tab_q;
    keys_on_d     = keys_on_q;
    active_d      = active_q;
    req_ready_d   = req_ready_q;
    alloc_valid_d = 1'b0;
    alloc_adr_d   = alloc_adr_q;
    alloc_key_d   = alloc_key_q;
    alloc_vel_d   = alloc_vel_q;
    alloc_on_d    = alloc_on_q;
    off_err_d     = 1'b0;
    fail_d        = 1'b0;
    hit           = 1'b0;
    sel           = '0;
`ifdef VOICE_STEAL_EN
    sp_d          = sp_q;
    steal_d       = 1'b0;
`endif
    // Candidate classes of the voice under examination this cycle
    cur_m = keys_on_q[idx_q] && (key_tab_q[idx_q] == key_q);
    cur_f = !keys_on_q[idx_q] && free_snap_q[idx_q];
    cur_r = !keys_on_q[idx_q] && !free_snap_q[idx_q];
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          key_d       = req_key;
          vel_d       = req_vel;
          on_d        = req_on;
          free_snap_d = voice_free;
          m_hit_d     = 1'b0;
          f_hit_d     = 1'b0;
          r_hit_d     = 1'b0;
          idx_d       = '0;
          req_ready_d = 1'b0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        // Only the first hit of each class is kept, so the lowest index wins
        if (cur_m && !m_hit_q) begin m_hit_d = 1'b1; m_idx_d = idx_q; end
        if (cur_f && !f_hit_q) begin f_hit_d = 1'b1; f_idx_d = idx_q; end
        if (cur_r && !r_hit_q) begin r_hit_d = 1'b1; r_idx_d = idx_q; end
        idx_d = idx_q + 1'b1;
        // The last scan cycle resolves the request so that ISSUE shows
        // registered results
        if (idx_q == LAST) begin
          state_d = ISSUE;
          if (on_q) begin
            hit = 1'b1;
            if (m_hit_d)      sel = m_idx_d;
            else if (f_hit_d) sel = f_idx_d;
            else if (r_hit_d) begin
              sel = r_idx_d;
`ifdef VOICE_STEAL_EN
              steal_d = 1'b1;
`endif
            end else begin
`ifdef VOICE_STEAL_EN
              sel     = sp_q;
              sp_d    = sp_q + 1'b1;
              steal_d = 1'b1;
`else
              hit     = 1'b0;
`endif
            end
            if (hit) begin
              key_tab_d[sel] = key_q;
              keys_on_d[sel] = 1'b1;
              if (!keys_on_q[sel]) active_d = active_q + (V_WIDTH+1)'(1);
              alloc_valid_d = 1'b1;
              alloc_adr_d   = sel;
              alloc_key_d   = key_q;
              alloc_vel_d   = vel_q;
              alloc_on_d    = 1'b1;
            end else begin
              fail_d = 1'b1;
            end
          end else if (m_hit_d) begin
            keys_on_d[m_idx_d] = 1'b0;
            active_d      = active_q - (V_WIDTH+1)'(1);
            alloc_valid_d = 1'b1;
            alloc_adr_d   = m_idx_d;
            alloc_key_d   = key_q;
            alloc_vel_d   = vel_q;
            alloc_on_d    = 1'b0;
          end else begin
            off_err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any request in flight
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      key_q         <= '0;
      vel_q         <= '0;
      on_q          <= 1'b0;
      free_snap_q   <= '0;
      m_hit_q       <= 1'b0;
      f_hit_q       <= 1'b0;
      r_hit_q       <= 1'b0;
      m_idx_q       <= '0;
      f_idx_q       <= '0;
      r_idx_q       <= '0;
      key_tab_q     <= '0;
      keys_on_q     <= '0;
      active_q      <= '0;
      req_ready_q   <= 1'b1;
      alloc_valid_q <= 1'b0;
      alloc_adr_q   <= '0;
      alloc_key_q   <= '0;
      alloc_vel_q   <= '0;
      alloc_on_q    <= 1'b0;
      off_err_q     <= 1'b0;
      fail_q        <= 1'b0;
`ifdef VOICE_STEAL_EN
      sp_q          <= '0;
      steal_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      key_q         <= key_d;
      vel_q         <= vel_d;
      on_q          <= on_d;
      free_snap_q   <= free_snap_d;
      m_hit_q       <= m_hit_d;
      f_hit_q       <= f_hit_d;
      r_hit_q       <= r_hit_d;
      m_idx_q       <= m_idx_d;
      f_idx_q       <= f_idx_d;
      r_idx_q       <= r_idx_d;
      key_tab_q     <= key_tab_d;
      keys_on_q     <= keys_on_d;
      active_q      <= active_d;
      req_ready_q   <= req_ready_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_adr_q   <= alloc_adr_d;
      alloc_key_q   <= alloc_key_d;
      alloc_vel_q   <= alloc_vel_d;
      alloc_on_q    <= alloc_on_d;
      off_err_q     <= off_err_d;
      fail_q        <= fail_d;
`ifdef VOICE_STEAL_EN
      sp_q          <= sp_d;
      steal_q       <= steal_d;
`endif
    end
  end

  assign req_ready      = req_ready_q;
  assign alloc_valid    = alloc_valid_q;
  assign alloc_adr      = alloc_adr_q;
  assign alloc_key      = alloc_key_q;
  assign alloc_vel      = alloc_vel_q;
  assign alloc_on       = alloc_on_q;
  assign keys_on        = keys_on_q;
  assign active_keys    = active_q;
  assign off_note_error = off_err_q;
  assign alloc_fail     = fail_q;
`ifdef VOICE_STEAL_EN
  assign steal          = steal_q;
`else
  assign steal          = 1'b0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: scoreboard bench for voice_allocator (VOICES=32).
module tb_voice_allocator;
  localparam int VOICES = 32;
  localparam int VW     = 5;
`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif
  localparam logic [1:0] K_VALID = 2'd0, K_ERR = 2'd1, K_FAIL = 2'd2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, req_on = 1'b0;
  logic [7:0]        req_key = '0, req_vel = '0;
  logic [VOICES-1:0] voice_free = '1;
  logic              req_ready, alloc_valid, alloc_on, steal, off_note_error, alloc_fail;
  logic [VW-1:0]     alloc_adr;
  logic [7:0]        alloc_key, alloc_vel;
  logic [VOICES-1:0] keys_on;
  logic [VW:0]       active_keys;

  typedef struct {
    logic [1:0]    kind;
    logic [VW-1:0] adr;
    logic [7:0]    key;
    logic [7:0]    vel;
    logic          on;
    logic          stl;
  } exp_t;

  exp_t              sb[$];
  logic [VOICES-1:0] model_keys = '0;
  int                total = 0;
  int                bad = 0;

  voice_allocator #(.VOICES(VOICES)) dut (
    .reg_clk(clk), .reset_reg_N(rst_n), .req_valid(req_valid), .req_on(req_on),
    .req_key(req_key), .req_vel(req_vel), .voice_free(voice_free),
    .req_ready(req_ready), .alloc_valid(alloc_valid), .alloc_adr(alloc_adr),
    .alloc_key(alloc_key), .alloc_vel(alloc_vel), .alloc_on(alloc_on),
    .keys_on(keys_on), .active_keys(active_keys), .steal(steal),
    .off_note_error(off_note_error), .alloc_fail(alloc_fail)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    model_keys = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request, then pop its expectation when the result pulse appears
  task automatic send(input logic on, input logic [7:0] key, input logic [7:0] vel,
                      input logic [1:0] kind, input logic [VW-1:0] adr, input logic stl);
    exp_t e;
    int   n;
    int   lat;
    e.kind = kind; e.adr = adr; e.key = key; e.vel = vel; e.on = on; e.stl = stl;
    sb.push_back(e);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_on = on; req_key = key; req_vel = vel;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= VOICES + 6 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL ready_busy got=%b exp=0", req_ready); end
      end
      if (alloc_valid || off_note_error || alloc_fail) lat = c;
    end
    e = sb.pop_front();
    total++;
    if (lat != VOICES + 1) begin
      bad++; $display("FAIL latency key=%0d got=%0d exp=%0d", key, lat, VOICES + 1);
    end
    if (lat != 0) begin
      total += 4;
      if (alloc_valid !== (e.kind == K_VALID)) begin bad++; $display("FAIL alloc_valid key=%0d got=%b exp=%b", key, alloc_valid, e.kind == K_VALID); end
      if (off_note_error !== (e.kind == K_ERR)) begin bad++; $display("FAIL off_err key=%0d got=%b exp=%b", key, off_note_error, e.kind == K_ERR); end
      if (alloc_fail !== (e.kind == K_FAIL)) begin bad++; $display("FAIL alloc_fail key=%0d got=%b exp=%b", key, alloc_fail, e.kind == K_FAIL); end
      if (steal !== e.stl) begin bad++; $display("FAIL steal key=%0d got=%b exp=%b", key, steal, e.stl); end
      if (e.kind == K_VALID) begin
        total++;
        if ({alloc_adr, alloc_key, alloc_vel, alloc_on} !== {e.adr, e.key, e.vel, e.on}) begin
          bad++;
          $display("FAIL alloc_fields got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b",
                   alloc_adr, alloc_key, alloc_vel, alloc_on, e.adr, e.key, e.vel, e.on);
        end
        if (e.on) model_keys[e.adr] = 1'b1;
        else      model_keys[e.adr] = 1'b0;
      end
      total += 2;
      if (keys_on !== model_keys) begin bad++; $display("FAIL keys_on got=%h exp=%h", keys_on, model_keys); end
      if (active_keys !== (VW+1)'($countones(model_keys))) begin
        bad++; $display("FAIL active_keys got=%0d exp=%0d", active_keys, $countones(model_keys));
      end
      @(negedge clk);
      total++;
      if ({req_ready, alloc_valid, off_note_error, alloc_fail, steal} !== 5'b10000) begin
        bad++; $display("FAIL post_issue got=%b exp=10000", {req_ready, alloc_valid, off_note_error, alloc_fail, steal});
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({req_ready, alloc_valid, steal, off_note_error, alloc_fail, alloc_on} !== 6'b100000) begin
      bad++; $display("FAIL reset_flags got=%b exp=100000", {req_ready, alloc_valid, steal, off_note_error, alloc_fail, alloc_on});
    end
    total++;
    if ({keys_on, active_keys, alloc_adr, alloc_key, alloc_vel} !== '0) begin
      bad++; $display("FAIL reset_values keys=%h act=%0d adr=%0d", keys_on, active_keys, alloc_adr);
    end
  endtask

  task automatic test_note_on_retrigger();
    voice_free = '1;
    send(1'b1, 8'd60, 8'd100, K_VALID, 5'd0, 1'b0);
    send(1'b1, 8'd60, 8'd90,  K_VALID, 5'd0, 1'b0);
  endtask

  task automatic test_note_off();
    send(1'b0, 8'd61, 8'd40, K_ERR, 5'd0, 1'b0);
    total++;
    if (alloc_adr !== 5'd0) begin bad++; $display("FAIL off_err_adr got=%0d exp=0", alloc_adr); end
    send(1'b0, 8'd60, 8'd41, K_VALID, 5'd0, 1'b0);
  endtask

  task automatic test_full_pool();
    voice_free = '1;
    for (int i = 0; i < VOICES; i++) send(1'b1, 8'(i), 8'(i + 1), K_VALID, VW'(i), 1'b0);
    if (STEAL) begin
      send(1'b1, 8'd100, 8'd7, K_VALID, 5'd0, 1'b1);
      send(1'b1, 8'd101, 8'd8, K_VALID, 5'd1, 1'b1);
    end else begin
      send(1'b1, 8'd100, 8'd7, K_FAIL, 5'd0, 1'b0);
    end
    total++;
    if (keys_on !== '1) begin bad++; $display("FAIL full_keys got=%h exp=ffffffff", keys_on); end
  endtask

  task automatic test_free_before_release();
    do_reset();
    voice_free = '1;
    send(1'b1, 8'd10, 8'd50, K_VALID, 5'd0, 1'b0);
    send(1'b0, 8'd10, 8'd0,  K_VALID, 5'd0, 1'b0);
    voice_free = 32'hFFFF_FFFE;
    fork
      begin
        @(negedge req_ready);
        repeat (VOICES) begin @(negedge clk); voice_free = $urandom; end
      end
    join_none
    send(1'b1, 8'd20, 8'd60, K_VALID, 5'd1, 1'b0);
    voice_free = '0;
    send(1'b1, 8'd30, 8'd70, K_VALID, 5'd0, STEAL);
    voice_free = '1;
  endtask

  task automatic test_reset_mid_scan();
    int pulses;
    do_reset();
    send(1'b1, 8'd50, 8'd1, K_VALID, 5'd0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_on = 1'b1; req_key = 8'd51; req_vel = 8'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    model_keys = '0;
    @(negedge clk);
    total++;
    if ({keys_on, active_keys} !== '0) begin bad++; $display("FAIL midscan_clear keys=%h act=%0d", keys_on, active_keys); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL midscan_ready got=%b exp=1", req_ready); end
    pulses = 0;
    repeat (VOICES + 4) begin
      @(negedge clk);
      if (alloc_valid || off_note_error || alloc_fail) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL midscan_pulse got=%0d exp=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_note_on_retrigger();
    test_note_off();
    test_full_pool();
    test_free_before_release();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
